// File: rtl/divider_32bit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU): one trial subtraction a + ~b + 1 per cycle.
// Optional build macro DIVIDER_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration.
module divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = WIDTH + 2;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_dvd_mag;
    logic [WIDTH-1:0] r_dvs_mag;
    logic [WIDTH-1:0] r_dvd_orig;
    logic [WIDTH-1:0] r_part_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic             r_overflow;
    logic [CW-1:0]    r_count;

    logic             w_in_div_zero;
    logic             w_in_overflow;
    logic [WIDTH-1:0] w_dvd_mag_in;
    logic [WIDTH-1:0] w_dvs_mag_in;
    logic [WIDTH:0]   w_shift_rem;
    logic [SW-1:0]    w_sub;
    logic             w_no_borrow;
    logic [WIDTH-1:0] w_next_rem;
    logic [WIDTH-1:0] w_next_quot;
    logic [WIDTH-1:0] w_fin_q;
    logic [WIDTH-1:0] w_fin_r;
    logic             w_last;
    logic             w_unused;

    assign w_in_div_zero = (divisor == '0);
    assign w_in_overflow = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    assign w_dvd_mag_in  = (is_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    assign w_dvs_mag_in  = (is_signed && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;

`ifdef DIVIDER_EARLY_OUT_EN
    logic w_in_special;
    assign w_in_special = w_in_div_zero || w_in_overflow;
`endif

    // The kept remainder is always below the divisor, so WIDTH bits suffice between
    // steps; the shifted trial value needs WIDTH+1, and bit WIDTH+1 of w_sub is the no-borrow carry.
    assign w_shift_rem = {r_part_rem, r_dvd_mag[WIDTH-1]};
    assign w_sub       = {1'b0, w_shift_rem} + {1'b0, ~{1'b0, r_dvs_mag}} + SW'(1);
    assign w_no_borrow = w_sub[WIDTH+1];
    assign w_next_rem  = w_no_borrow ? w_sub[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
    assign w_next_quot = {r_quot[WIDTH-2:0], w_no_borrow};
    assign w_last      = (r_count == CW'(1));
    assign w_unused    = ^{w_sub[WIDTH], r_quot[WIDTH-1]};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_fin_q = r_neg_q ? (~w_next_quot + WIDTH'(1)) : w_next_quot;
        w_fin_r = r_neg_r ? (~w_next_rem + WIDTH'(1)) : w_next_rem;
        if (r_div_zero) begin
            w_fin_q = '1;
            w_fin_r = r_dvd_orig;
        end else if (r_overflow) begin
            w_fin_q = MIN_NEG;
            w_fin_r = '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
`ifdef DIVIDER_EARLY_OUT_EN
                    w_next_state = w_in_special ? DONE : CALC;
`else
                    w_next_state = CALC;
`endif
                end
            end
            CALC:    if (w_last) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dvd_mag   <= '0;
            r_dvs_mag   <= '0;
            r_dvd_orig  <= '0;
            r_part_rem  <= '0;
            r_quot      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dvd_mag  <= w_dvd_mag_in;
                        r_dvs_mag  <= w_dvs_mag_in;
                        r_dvd_orig <= dividend;
                        r_neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r    <= is_signed && dividend[WIDTH-1];
                        r_div_zero <= w_in_div_zero;
                        r_overflow <= w_in_overflow;
                        r_part_rem <= '0;
                        r_quot     <= '0;
                        r_count    <= CW'(WIDTH);
`ifdef DIVIDER_EARLY_OUT_EN
                        if (w_in_special) begin
                            r_count     <= '0;
                            r_quotient  <= w_in_div_zero ? '1 : MIN_NEG;
                            r_remainder <= w_in_div_zero ? dividend : '0;
                        end
`endif
                    end
                end
                CALC: begin
                    r_part_rem <= w_next_rem;
                    r_quot     <= w_next_quot;
                    r_dvd_mag  <= {r_dvd_mag[WIDTH-2:0], 1'b0};
                    r_count    <= r_count - CW'(1);
                    if (w_last) begin
                        r_quotient  <= w_fin_q;
                        r_remainder <= w_fin_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_divider_32bit.sv
// Directed self-checking bench for divider_32bit; honours DIVIDER_EARLY_OUT_EN for expected latency.
module tb_divider_32bit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DIVIDER_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    divider_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble inputs after accept, wait for out_valid, check result and latency.
    // Returns at the negedge of the first out_valid cycle.
    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic sgn, input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input int exp_lat);
        int lat;
        bit found;
        @(negedge clk);
        check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        dividend  = dvd;
        divisor   = dvs;
        is_signed = sgn;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = ~dvd;
        divisor   = dvs + 32'd3;
        is_signed = ~sgn;
        lat   = 0;
        found = 1'b0;
        for (int c = 1; c <= 100 && !found; c++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                lat   = c;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
    endtask

    // With out_ready high: result must last exactly one cycle, in_ready returns the cycle after.
    task automatic finish_op(input string tag);
        check({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_vdrop"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
        finish_op("u100_7");
        run_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        finish_op("s-7_2");
        run_op("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33);
        finish_op("s7_-2");
        run_op("s-100_-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 33);
        finish_op("s-100_-7");
        run_op("umax_16", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 33);
        finish_op("umax_16");
        run_op("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, SPECIAL_LAT);
        finish_op("u5_0");
        run_op("s-5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, SPECIAL_LAT);
        finish_op("s-5_0");
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, SPECIAL_LAT);
        finish_op("s_ovf");
        run_op("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 33);
        finish_op("u_ovf");

        // Backpressure: result held for 10 cycles while a new request is offered and refused.
        out_ready = 1'b0;
        run_op("bp", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 33);
        in_valid = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_ready", {31'b0, in_ready}, 32'd0);
            check("bp_q", quotient, 32'd100);
            check("bp_r", remainder, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_vdrop", {31'b0, out_valid}, 32'd0);
        check("bp_idle", {31'b0, in_ready}, 32'd1);

        // Reset in cycle 10 of a CALC, with in_valid high during reset.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        is_signed = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("abort_ready", {31'b0, in_ready}, 32'd1);
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_noresult", {31'b0, seen}, 32'd0);
        run_op("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);
        finish_op("u9_3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
